// File: rtl/start_token_srl_ctrl.sv
// Round-robin push arbiter and occupancy tracker in front of a start-token SRL.
// Optional status outputs (if_count, err_underflow) are enabled by defining START_FIFO_STATUS_EN.
module start_token_srl_ctrl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2,
  parameter int NUM_SRC    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC-1:0]            src_req,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_din,
  output logic [NUM_SRC-1:0]            src_grant,
  output logic                          if_full_n,
  output logic                          if_empty_n,
  input  logic                          if_read,
  output logic [DATA_WIDTH-1:0]         if_dout,
`ifdef START_FIFO_STATUS_EN
  output logic [ADDR_WIDTH:0]           if_count,
  output logic                          err_underflow,
`endif
  output logic                          srl_we,
  output logic [DATA_WIDTH-1:0]         srl_din,
  output logic [ADDR_WIDTH-1:0]         srl_addr,
  input  logic [DATA_WIDTH-1:0]         srl_dout
);

  localparam int RR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [RR_W-1:0]       rr_q, rr_d;
  logic                  full_n_q, full_n_d;
  logic                  empty_n_q, empty_n_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic                  found;
  logic [RR_W-1:0]       gidx;
  logic [DATA_WIDTH-1:0] din_sel;
  logic                  push, pop;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    found     = 1'b0;
    gidx      = '0;
    din_sel   = '0;
    src_grant = '0;
    // Scan upward from rr_q, wrapping, and take the first requester; no grant while full.
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && full_n_q && !reset && src_req[(int'(rr_q) + i) % NUM_SRC]) begin
        found   = 1'b1;
        gidx    = RR_W'((int'(rr_q) + i) % NUM_SRC);
        din_sel = src_din[((int'(rr_q) + i) % NUM_SRC)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (found) src_grant[gidx] = 1'b1;
  end

  assign push = found;
  assign pop  = if_read & empty_n_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    addr_d    = (count_d == '0) ? '0 : ADDR_WIDTH'(count_d - 1'b1);
    empty_n_d = (count_d != '0);
    full_n_d  = (count_d != DEPTH_C);
    rr_d      = rr_q;
    if (found) rr_d = (gidx == RR_W'(NUM_SRC-1)) ? '0 : gidx + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      rr_q      <= '0;
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
      addr_q    <= '0;
    end else begin
      count_q   <= count_d;
      rr_q      <= rr_d;
      full_n_q  <= full_n_d;
      empty_n_q <= empty_n_d;
      addr_q    <= addr_d;
    end
  end

`ifdef START_FIFO_STATUS_EN
  logic err_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_q | (if_read & ~empty_n_q);
  end
  assign if_count      = count_q;
  assign err_underflow = err_q;
`endif

  assign if_full_n  = full_n_q;
  assign if_empty_n = empty_n_q;
  assign if_dout    = srl_dout;
  assign srl_we     = found;
  assign srl_din    = din_sel;
  assign srl_addr   = addr_q;

endmodule

// File: tb/tb_start_token_srl_ctrl.sv
// Bench for start_token_srl_ctrl: SRL array model plus a token-queue reference with round-robin pointer.
module tb_start_token_srl_ctrl;
  localparam int DATA_WIDTH = 1;
  localparam int ADDR_WIDTH = 1;
  localparam int DEPTH      = 2;
  localparam int NUM_SRC    = 2;

  logic                          clk = 1'b0;
  logic                          reset;
  logic [NUM_SRC-1:0]            src_req;
  logic [NUM_SRC*DATA_WIDTH-1:0] src_din;
  logic [NUM_SRC-1:0]            src_grant;
  logic                          if_full_n, if_empty_n, if_read;
  logic [DATA_WIDTH-1:0]         if_dout;
  logic                          srl_we;
  logic [DATA_WIDTH-1:0]         srl_din;
  logic [ADDR_WIDTH-1:0]         srl_addr;
  logic [DATA_WIDTH-1:0]         srl_dout;
`ifdef START_FIFO_STATUS_EN
  logic [ADDR_WIDTH:0]           if_count;
  logic                          err_underflow;
`endif

  int total = 0;
  int bad   = 0;

  logic [DATA_WIDTH-1:0] model_q[$];
  int                    model_rr;

  logic [DATA_WIDTH-1:0] srl_mem [2**ADDR_WIDTH];

  always #5 clk = ~clk;

  start_token_srl_ctrl #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH), .NUM_SRC(NUM_SRC)
  ) dut (
    .clk(clk), .reset(reset),
    .src_req(src_req), .src_din(src_din), .src_grant(src_grant),
    .if_full_n(if_full_n), .if_empty_n(if_empty_n), .if_read(if_read), .if_dout(if_dout),
`ifdef START_FIFO_STATUS_EN
    .if_count(if_count), .err_underflow(err_underflow),
`endif
    .srl_we(srl_we), .srl_din(srl_din), .srl_addr(srl_addr), .srl_dout(srl_dout)
  );

  // The SRL itself: shifts toward higher index on write, never reset.
  always @(posedge clk) begin
    if (srl_we) begin
      for (int k = 2**ADDR_WIDTH - 1; k > 0; k--) srl_mem[k] <= srl_mem[k-1];
      srl_mem[0] <= srl_din;
    end
  end
  assign srl_dout = srl_mem[srl_addr];

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_full_n"},  if_full_n,  1);
    check({tag, "_empty_n"}, if_empty_n, 0);
    check({tag, "_addr"},    srl_addr,   0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    src_req = '1; src_din = '0; if_read = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_idle_state("rst_async");
    check("rst_grant", src_grant, 0);
    check("rst_we", srl_we, 0);
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; src_req = '0;
    model_q.delete();
    model_rr = 0;
  endtask

  // One cycle: drive at negedge, check against the model, advance the model, settle after posedge.
  task automatic step(input logic [NUM_SRC-1:0] req, input logic [NUM_SRC*DATA_WIDTH-1:0] din,
                      input logic rd);
    int                   g;
    int                   sz;
    logic [NUM_SRC-1:0]   exp_grant;
    logic [DATA_WIDTH-1:0] tok;
    @(negedge clk);
    src_req = req; src_din = din; if_read = rd;
    #1;
    sz = model_q.size();
    g = -1;
    exp_grant = '0;
    if (sz < DEPTH) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (g < 0 && req[(model_rr + i) % NUM_SRC]) g = (model_rr + i) % NUM_SRC;
      end
    end
    if (g >= 0) exp_grant[g] = 1'b1;
    check("grant", src_grant, exp_grant);
    check("srl_we", srl_we, (g >= 0));
    if (g >= 0) begin
      tok = din[g*DATA_WIDTH +: DATA_WIDTH];
      check("srl_din", srl_din, tok);
    end
    check("full_n", if_full_n, (sz != DEPTH));
    check("empty_n", if_empty_n, (sz != 0));
    check("srl_addr", srl_addr, (sz > 0) ? sz - 1 : 0);
    if (sz > 0) check("if_dout", if_dout, model_q[0]);
    if (rd && sz > 0) void'(model_q.pop_front());
    if (g >= 0) begin
      model_q.push_back(din[g*DATA_WIDTH +: DATA_WIDTH]);
      model_rr = (g + 1) % NUM_SRC;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; src_req = '0; src_din = '0; if_read = 1'b0;
    model_rr = 0;
    for (int k = 0; k < 2**ADDR_WIDTH; k++) srl_mem[k] = '0;

    // 1: reset held three cycles
    do_reset(3);
    #1;
    check_idle_state("t1");
    check("t1_grant", src_grant, 0);

    // 2: single push from source 0
    step(2'b01, 2'b01, 1'b0);
    check("t2_empty_n", if_empty_n, 1);
    check("t2_addr", srl_addr, 0);
    check("t2_dout", if_dout, 1);

    // 3: both request for four cycles from a fresh reset
    do_reset(3);
    step(2'b11, 2'b10, 1'b0);
    step(2'b11, 2'b10, 1'b0);
    check("t3_full_n", if_full_n, 0);
    step(2'b11, 2'b10, 1'b0);
    step(2'b11, 2'b10, 1'b0);
    check("t3_addr", srl_addr, 1);
    check("t3_rr", model_rr, 0);

    // 4: full, push request plus read -> pop only
    step(2'b01, 2'b01, 1'b1);
    check("t4_full_n", if_full_n, 1);
    check("t4_addr", srl_addr, 0);
    check("t4_empty_n", if_empty_n, 1);

    // 5: count=1, simultaneous push and pop
    step(2'b01, 2'b00, 1'b1);
    check("t5_addr", srl_addr, 0);
    check("t5_dout", if_dout, 0);
    check("t5_empty_n", if_empty_n, 1);
    check("t5_full_n", if_full_n, 1);

    // 6: drain, then read while empty
    step(2'b00, 2'b00, 1'b1);
    check_idle_state("t6a");
    step(2'b00, 2'b00, 1'b1);
    check_idle_state("t6b");
`ifdef START_FIFO_STATUS_EN
    check("t6_err", err_underflow, 1);
    step(2'b01, 2'b01, 1'b0);
    check("t6_err_sticky", err_underflow, 1);
    check("t6_count", if_count, 1);
`endif

    // Random traffic with occasional mid-operation resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset($urandom_range(1, 3));
`ifdef START_FIFO_STATUS_EN
        #1 check("rnd_err_clr", err_underflow, 0);
`endif
      end
      step(NUM_SRC'($urandom), (NUM_SRC*DATA_WIDTH)'($urandom), 1'($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
